// File: rtl/wb_master_burst.sv
// wb_master_burst
//   Wishbone classic burst master. One request moves len+1 beats starting at
//   addr, stepping the address by ADDR_INC after every acknowledged beat.
//   Writes fetch each beat's data through a wd_valid/wd_ready handshake (LOAD)
//   before presenting it on the bus (XFER). Reads stream back-to-back, and every
//   beat returns through rdata/rvalid. Each burst ends with one DONE cycle that
//   pulses done and reports status.
//
// Optional feature macro: WB_MASTER_TIMEOUT_EN
//   When defined, a watchdog aborts a beat that waits TIMEOUT_CYC cycles for
//   ack/err, and the burst ends with status 2'b10. When undefined, the master
//   waits indefinitely.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req/req_rdy         burst request, accepted when both are high (IDLE only)
//   wr, addr, sel, len  direction, start address, byte enables, beats-1
//   wd_valid/wd_ready   write-data handshake, wd_data captured in LOAD
//   rdata, rvalid       read beat data and one-cycle valid pulse
//   done, status        burst-end pulse; 00 ok, 01 bus error, 10 timeout
//   busy                high whenever not IDLE
//   m_wb_*              Wishbone master side
module wb_master_burst #(
  parameter int ADDR_WID    = 32,
  parameter int DATA_WID    = 32,
  parameter int LEN_WID     = 4,
  parameter int ADDR_INC    = DATA_WID / 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    req,
  output logic                    req_rdy,
  input  logic                    wr,
  input  logic [ADDR_WID-1:0]     addr,
  input  logic [DATA_WID/8-1:0]   sel,
  input  logic [LEN_WID-1:0]      len,

  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WID-1:0]     wd_data,

  output logic [DATA_WID-1:0]     rdata,
  output logic                    rvalid,
  output logic                    done,
  output logic [1:0]              status,
  output logic                    busy,

  output logic                    m_wb_clk_o,
  output logic [ADDR_WID-1:0]     m_wb_addr_o,
  output logic [DATA_WID-1:0]     m_wb_data_o,
  input  logic [DATA_WID-1:0]     m_wb_data_i,
  output logic [DATA_WID/8-1:0]   m_wb_sel_o,
  output logic                    m_wb_we_o,
  output logic                    m_wb_cyc_o,
  output logic                    m_wb_stb_o,
  input  logic                    m_wb_ack_i,
  input  logic                    m_wb_err_i
);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    XFER,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [LEN_WID-1:0]  beat_cnt;
  logic                tmo_hit;

  if (DATA_WID % 8 != 0 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("wb_master_burst: DATA_WID must be a multiple of 8 and TIMEOUT_CYC at least 1");
  end

  assign m_wb_clk_o = clk_i;
  assign m_wb_cyc_o = (state == LOAD) || (state == XFER);
  assign m_wb_stb_o = (state == XFER);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [1:0] ST_TMO  = 2'b10;
  localparam int         TMO_WID = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_WID-1:0] tmo_cnt;

  // Holding at zero outside XFER covers the clear on entry to XFER.
  always_ff @(posedge clk_i) begin
    if (rst_i || state != XFER || m_wb_ack_i) begin
      tmo_cnt <= '0;
    end else if (!m_wb_err_i) begin
      tmo_cnt <= tmo_cnt + TMO_WID'(1);
    end
  end

  // Fires on the TIMEOUT_CYC-th consecutive XFER cycle without ack/err.
  assign tmo_hit = (state == XFER) && !m_wb_ack_i && !m_wb_err_i &&
                   (tmo_cnt == TMO_WID'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = wr ? LOAD : XFER;
        end
      end
      LOAD: begin
        if (wd_valid && wd_ready) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (m_wb_err_i) begin
          state_nxt = DONE;
        end else if (m_wb_ack_i) begin
          if (beat_cnt == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = m_wb_we_o ? LOAD : XFER;
          end
        end else if (tmo_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Handshake and status outputs are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      req_rdy     <= 1'b1;
      wd_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rvalid      <= 1'b0;
      status      <= ST_OK;
      rdata       <= '0;
      m_wb_addr_o <= '0;
      m_wb_data_o <= '0;
      m_wb_sel_o  <= '0;
      m_wb_we_o   <= 1'b0;
      beat_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      req_rdy  <= (state_nxt == IDLE);
      wd_ready <= (state_nxt == LOAD);
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);
      rvalid   <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            m_wb_addr_o <= addr;
            m_wb_sel_o  <= sel;
            m_wb_we_o   <= wr;
            beat_cnt    <= len;
            status      <= ST_OK;
          end
        end
        LOAD: begin
          if (wd_valid && wd_ready) begin
            m_wb_data_o <= wd_data;
          end
        end
        XFER: begin
          if (m_wb_err_i) begin
            status <= ST_ERR;
          end else if (m_wb_ack_i) begin
            if (!m_wb_we_o) begin
              rdata  <= m_wb_data_i;
              rvalid <= 1'b1;
            end
            if (beat_cnt != '0) begin
              m_wb_addr_o <= m_wb_addr_o + ADDR_WID'(ADDR_INC);
              beat_cnt    <= beat_cnt - LEN_WID'(1);
            end else begin
              status <= ST_OK;
            end
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else if (tmo_hit) begin
            status <= ST_TMO;
          end
`endif
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
